// File: rtl/mips_stream_pkg.sv
// mips_stream_pkg: shared state encoding and default widths for the stream demux
package mips_stream_pkg;
  typedef enum logic {EMPTY, FULL} demux_state_t;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: enable-increment counter that silently wraps at 2^W-1
module wrap_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = en_i ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/stream_demux_1to2.sv
// stream_demux_1to2: one-deep registered 1-to-2 stream demux with per-output transfer counters
module stream_demux_1to2 #(
  parameter int NBits = mips_stream_pkg::DATA_W,
  parameter int CNT_W = mips_stream_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             in_sel_i,
  input  logic [NBits-1:0] in_data_i,
  output logic             out0_valid_o,
  input  logic             out0_ready_i,
  output logic [NBits-1:0] out0_data_o,
  output logic             out1_valid_o,
  input  logic             out1_ready_i,
  output logic [NBits-1:0] out1_data_o,
  output logic [CNT_W-1:0] cnt0_o,
  output logic [CNT_W-1:0] cnt1_o
);
  import mips_stream_pkg::*;
  demux_state_t     state_q, state_d;
  logic [NBits-1:0] data_q, data_d;
  logic             sel_q, sel_d;
  logic             fire0, fire1, out_fire, in_fire;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  // A simultaneous pop and push keeps the slot full, giving one word per cycle.
  always_comb begin
    state_d = in_fire ? FULL : (out_fire ? EMPTY : state_q);
    data_d  = in_fire ? in_data_i : data_q;
    sel_d   = in_fire ? in_sel_i : sel_q;
  end
  always_comb begin
    out0_valid_o = (state_q == FULL) & ~sel_q;
    out1_valid_o = (state_q == FULL) & sel_q;
    out0_data_o  = data_q;
    out1_data_o  = data_q;
    fire0        = out0_valid_o & out0_ready_i;
    fire1        = out1_valid_o & out1_ready_i;
    out_fire     = fire0 | fire1;
    in_ready_o   = (state_q == EMPTY) | out_fire;
    in_fire      = in_valid_i & in_ready_o;
  end
  wrap_counter #(.W(CNT_W)) u_cnt0 (.clk(clk), .rst_n(rst_n), .en_i(fire0), .cnt_o(cnt0_o));
  wrap_counter #(.W(CNT_W)) u_cnt1 (.clk(clk), .rst_n(rst_n), .en_i(fire1), .cnt_o(cnt1_o));
endmodule

// File: tb/tb_stream_demux_1to2.sv
// tb_stream_demux_1to2: table-driven cycle vectors plus directed stall, reset and wrap sequences
module tb_stream_demux_1to2;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, in_sel = 1'b0;
  logic [31:0] in_data = '0;
  logic        out0_valid, out0_ready = 1'b0, out1_valid, out1_ready = 1'b0;
  logic [31:0] out0_data, out1_data;
  logic [3:0]  cnt0, cnt1;
  int          total = 0, bad = 0;

  typedef struct {
    logic v, s; logic [31:0] d; logic r0, r1;
    logic e_ir, e_v0, e_v1; logic [31:0] e_d; logic [3:0] e_c0, e_c1;
  } vec_t;
  vec_t tbl[13];

  stream_demux_1to2 #(.NBits(32), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_sel_i(in_sel), .in_data_i(in_data),
    .out0_valid_o(out0_valid), .out0_ready_i(out0_ready), .out0_data_o(out0_data),
    .out1_valid_o(out1_valid), .out1_ready_i(out1_ready), .out1_data_o(out1_data),
    .cnt0_o(cnt0), .cnt1_o(cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [31:0] d, input logic r0, input logic r1);
    in_valid = v; in_sel = s; in_data = d; out0_ready = r0; out1_ready = r1;
  endtask

  task automatic outs(input string t, input logic ir, input logic v0, input logic v1,
                      input logic [31:0] d, input logic [3:0] c0, input logic [3:0] c1);
    chk({t, ".in_ready"}, 32'(in_ready), 32'(ir));
    chk({t, ".v0"}, 32'(out0_valid), 32'(v0));
    chk({t, ".v1"}, 32'(out1_valid), 32'(v1));
    chk({t, ".d0"}, out0_data, d);
    chk({t, ".d1"}, out1_data, d);
    chk({t, ".c0"}, 32'(cnt0), 32'(c0));
    chk({t, ".c1"}, 32'(cnt1), 32'(c1));
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    drive(0, 0, '0, 0, 0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // single DEADBEEF word to out1, then 8 alternating words at full rate
    tbl[0]  = '{1,1,32'hDEADBEEF,0,1, 1,0,0,32'h0,        0,0};
    tbl[1]  = '{0,0,32'hBAD0BAD0,0,1, 1,0,1,32'hDEADBEEF, 0,0};
    tbl[2]  = '{0,1,32'hBAD0BAD0,1,1, 1,0,0,32'hDEADBEEF, 0,1};
    tbl[3]  = '{1,0,32'h10000000,1,1, 1,0,0,32'hDEADBEEF, 0,1};
    tbl[4]  = '{1,1,32'h10000001,1,1, 1,1,0,32'h10000000, 0,1};
    tbl[5]  = '{1,0,32'h10000002,1,1, 1,0,1,32'h10000001, 1,1};
    tbl[6]  = '{1,1,32'h10000003,1,1, 1,1,0,32'h10000002, 1,2};
    tbl[7]  = '{1,0,32'h10000004,1,1, 1,0,1,32'h10000003, 2,2};
    tbl[8]  = '{1,1,32'h10000005,1,1, 1,1,0,32'h10000004, 2,3};
    tbl[9]  = '{1,0,32'h10000006,1,1, 1,0,1,32'h10000005, 3,3};
    tbl[10] = '{1,1,32'h10000007,1,1, 1,1,0,32'h10000006, 3,4};
    tbl[11] = '{0,0,32'hBAD0BAD0,1,1, 1,0,1,32'h10000007, 4,4};
    tbl[12] = '{0,0,32'hBAD0BAD0,1,1, 1,0,0,32'h10000007, 4,5};

    drive(0, 0, '0, 0, 0);
    #12 rst_n = 1'b1;
    tick();
    outs("rst0", 1, 0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r0, tbl[i].r1);
      #4;
      outs($sformatf("vec%0d", i), tbl[i].e_ir, tbl[i].e_v0, tbl[i].e_v1, tbl[i].e_d, tbl[i].e_c0, tbl[i].e_c1);
      tick();
    end

    // async reset while FULL: valids drop with no clock edge, counters clear
    drive(1, 0, 32'hCAFEF00D, 0, 0);
    tick();
    drive(0, 0, '0, 0, 0);
    #1;
    chk("full.v0", 32'(out0_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    outs("async", 1, 0, 0, 32'h0, 0, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rel.in_ready", 32'(in_ready), 1);

    // backpressure: A held on out0 for 5 stalled cycles while B waits
    do_reset();
    drive(1, 0, 32'hAAAA0000, 0, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 32'hBBBB1111, 0, 1);
      #4;
      outs($sformatf("stall%0d", i), 0, 1, 0, 32'hAAAA0000, 0, 0);
      tick();
    end
    drive(1, 1, 32'hBBBB1111, 1, 0);
    #4;
    outs("bp.accept", 1, 1, 0, 32'hAAAA0000, 0, 0);
    tick();
    drive(0, 0, 32'h0, 0, 1);
    #4;
    outs("bp.B", 1, 0, 1, 32'hBBBB1111, 1, 0);
    tick();
    #4;
    outs("bp.done", 1, 0, 0, 32'hBBBB1111, 1, 1);

    // head-of-line: X for stalled out1 blocks Y for ready out0
    do_reset();
    drive(1, 1, 32'h11111111, 1, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 32'h22222222, 1, 0);
      #4;
      outs($sformatf("hol%0d", i), 0, 0, 1, 32'h11111111, 0, 0);
      tick();
    end
    drive(1, 0, 32'h22222222, 1, 1);
    #4;
    outs("hol.x", 1, 0, 1, 32'h11111111, 0, 0);
    tick();
    drive(0, 0, 32'h0, 1, 0);
    #4;
    outs("hol.y", 1, 1, 0, 32'h22222222, 0, 1);
    tick();
    #4;
    outs("hol.done", 1, 0, 0, 32'h22222222, 1, 1);

    // 17 transfers to out0 on a 4-bit counter: ...,15,0,1
    do_reset();
    for (int i = 0; i < 19; i++) begin
      drive(i < 17, 0, 32'(i), 1, 0);
      #4;
      chk($sformatf("wrap%0d", i), 32'(cnt0), (i < 2) ? 32'd0 : 32'((i - 1) % 16));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
